// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives a synchronous-read instruction memory, buffers
// returned words in a 2-entry queue toward decode and handles redirects via a return-address stack.
module instruction_fetch #(
    parameter int ADDR_W = 10,
    parameter int INSTR_W = 19,
    parameter int STACK_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    output logic                               imem_en,
    output logic [ADDR_W-1:0]                  imem_addr,
    input  logic [INSTR_W-1:0]                 imem_rdata,
    output logic [INSTR_W-1:0]                 instr_out,
    output logic [ADDR_W-1:0]                  instr_pc,
    output logic                               instr_valid,
    input  logic                               instr_ready,
    input  logic                               redirect_valid,
    input  logic [ADDR_W-1:0]                  redirect_pc,
    input  logic [ADDR_W-1:0]                  redirect_target,
    input  logic                               call,
    input  logic                               ret,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_depth,
    output logic                               stack_overflow,
    output logic                               stack_underflow
);
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    // Handshake: a word moves to decode on a rising edge where instr_valid && instr_ready,
    // except in a redirect cycle, where the presented word is dropped instead.
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  fetch_pc;
    logic               inflight;
    logic [1:0]         q_count;
    logic               q_rd;
    logic               q_wr;
    logic [INSTR_W-1:0] q_data [2];
    logic [ADDR_W-1:0]  q_pc [2];
    logic [ADDR_W-1:0]  ras [STACK_DEPTH];

    logic               transfer;
    logic               issue;
    logic               push;
    logic               pop;
    logic               is_call;
    logic               is_ret;
    logic               stack_full;
    logic               stack_empty;
    logic [IDX_W-1:0]   push_idx;
    logic [IDX_W-1:0]   top_idx;
    logic [ADDR_W-1:0]  target;

    assign instr_valid = (q_count != 2'd0);
    assign instr_out   = q_data[q_rd];
    assign instr_pc    = q_pc[q_rd];
    assign imem_addr   = pc;

    assign transfer = instr_valid && instr_ready;
    // Outstanding work (queued + in flight) never exceeds the two queue slots.
    assign issue    = !redirect_valid && (((q_count + {1'b0, inflight}) < 2'd2) || transfer);
    assign imem_en  = rst_n && issue;
    assign push     = inflight && !redirect_valid;
    assign pop      = transfer && !redirect_valid;

    assign is_call     = redirect_valid && call;
    assign is_ret      = redirect_valid && ret && !call;
    assign stack_full  = (stack_depth == DEPTH_W'(STACK_DEPTH));
    assign stack_empty = (stack_depth == '0);
    assign push_idx    = IDX_W'(stack_depth);
    assign top_idx     = IDX_W'(stack_depth - DEPTH_W'(1));

    always_comb begin
        target = redirect_target;
        if (is_ret) begin
            target = stack_empty ? RESET_PC : ras[top_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc              <= RESET_PC;
            fetch_pc        <= '0;
            inflight        <= 1'b0;
            q_count         <= 2'd0;
            q_rd            <= 1'b0;
            q_wr            <= 1'b0;
            q_data[0]       <= '0;
            q_data[1]       <= '0;
            q_pc[0]         <= '0;
            q_pc[1]         <= '0;
            stack_depth     <= '0;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
        end else begin
            // A fetch issued in a redirect cycle never happens, so clearing inflight marks stale data.
            inflight <= issue;
            if (issue) begin
                fetch_pc <= pc;
                pc       <= pc + ADDR_W'(1);
            end
            if (redirect_valid) begin
                pc      <= target;
                q_count <= 2'd0;
                q_rd    <= 1'b0;
                q_wr    <= 1'b0;
            end else begin
                if (push) begin
                    q_data[q_wr] <= imem_rdata;
                    q_pc[q_wr]   <= fetch_pc;
                    q_wr         <= ~q_wr;
                end
                if (pop) begin
                    q_rd <= ~q_rd;
                end
                q_count <= q_count + {1'b0, push} - {1'b0, pop};
            end
            if (is_call) begin
                if (stack_full) stack_overflow <= 1'b1;
                else            stack_depth <= stack_depth + DEPTH_W'(1);
            end
            if (is_ret) begin
                if (stack_empty) stack_underflow <= 1'b1;
                else             stack_depth <= stack_depth - DEPTH_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (is_call && !stack_full) begin
            ras[push_idx] <= redirect_pc + ADDR_W'(1);
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a memory model returns address-derived words,
// stimulus queues expected (pc, word) pairs and a negedge monitor compares every transfer.
module tb_instruction_fetch;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_en;
    logic [9:0]  imem_addr;
    logic [18:0] imem_rdata = '0;
    logic [18:0] instr_out;
    logic [9:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_valid;
    logic [9:0]  redirect_pc;
    logic [9:0]  redirect_target;
    logic        call;
    logic        ret;
    logic [3:0]  stack_depth;
    logic        stack_overflow;
    logic        stack_underflow;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [28:0] exp_q[$];

    instruction_fetch dut (
        .clk(clk), .rst_n(rst_n), .imem_en(imem_en), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .instr_out(instr_out), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_target(redirect_target), .call(call), .ret(ret),
        .stack_depth(stack_depth), .stack_overflow(stack_overflow),
        .stack_underflow(stack_underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [18:0] word(input logic [9:0] a);
        return {a[3:0] ^ 4'hA, a, a[4:0] ^ 5'h15};
    endfunction

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= word(imem_addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: every accepted transfer must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && instr_valid && instr_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_transfer: got pc %0h with nothing expected", instr_pc);
            end else begin
                logic [28:0] e;
                e = exp_q.pop_front();
                check("stream_pc", 32'(instr_pc), 32'(e[28:19]));
                check("stream_instr", 32'(instr_out), 32'(e[18:0]));
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic stream(input logic [9:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            logic [9:0] a;
            a = start + 10'(i);
            exp_q.push_back({a, word(a)});
        end
        repeat (n) next_cycle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_imem_en", 32'(imem_en), 32'd0);
        check("rst_imem_addr", 32'(imem_addr), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr_out", 32'(instr_out), 32'd0);
        check("rst_instr_pc", 32'(instr_pc), 32'd0);
        check("rst_depth", 32'(stack_depth), 32'd0);
        check("rst_overflow", 32'(stack_overflow), 32'd0);
        check("rst_underflow", 32'(stack_underflow), 32'd0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check("boot_imem_en", 32'(imem_en), 32'd1);
        check("boot_imem_addr", 32'(imem_addr), 32'd0);
        check("boot_valid_c0", 32'(instr_valid), 32'd0);
        next_cycle();
        @(negedge clk);
        check("boot_valid_c1", 32'(instr_valid), 32'd0);
        next_cycle();
    endtask

    task automatic redirect(input logic [9:0] rpc, input logic [9:0] tgt, input logic c,
                            input logic r, input logic [9:0] exp_tgt, input logic [3:0] exp_depth);
        redirect_valid = 1'b1;
        redirect_pc = rpc;
        redirect_target = tgt;
        call = c;
        ret = r;
        next_cycle();
        redirect_valid = 1'b0;
        call = 1'b0;
        ret = 1'b0;
        @(negedge clk);
        check("redir_valid_n1", 32'(instr_valid), 32'd0);
        check("redir_imem_en", 32'(imem_en), 32'd1);
        check("redir_target", 32'(imem_addr), 32'(exp_tgt));
        check("redir_depth", 32'(stack_depth), 32'(exp_depth));
        next_cycle();
        @(negedge clk);
        check("redir_valid_n2", 32'(instr_valid), 32'd0);
        next_cycle();
    endtask

    initial begin
        rst_n = 1'b0;
        instr_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        redirect_target = '0;
        call = 1'b0;
        ret = 1'b0;
        next_cycle();
        do_reset();
        stream(10'h000, 3);

        // Backpressure while pc 3 is at the head.
        instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(instr_valid), 32'd1);
            check("hold_pc", 32'(instr_pc), 32'h3);
            check("hold_instr", 32'(instr_out), 32'(word(10'h3)));
            if (i >= 1) check("hold_fetch_stopped", 32'(imem_en), 32'd0);
            next_cycle();
        end
        instr_ready = 1'b1;
        stream(10'h003, 5);

        redirect(10'h010, 10'h100, 1'b0, 1'b0, 10'h100, 4'd0);
        stream(10'h100, 3);

        redirect(10'h020, 10'h200, 1'b1, 1'b0, 10'h200, 4'd1);
        stream(10'h200, 2);
        redirect(10'h201, 10'h155, 1'b0, 1'b1, 10'h021, 4'd0);
        stream(10'h021, 2);

        for (int i = 0; i < 9; i++) begin
            redirect(10'h040 + 10'(i), 10'h080 + 10'(i * 16), 1'b1, 1'b0,
                     10'h080 + 10'(i * 16), (i < 8) ? 4'(i + 1) : 4'd8);
            check("call_overflow", 32'(stack_overflow), (i == 8) ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < 9; i++) begin
            redirect(10'h300, 10'h155, 1'b0, 1'b1, (i < 8) ? 10'h048 - 10'(i) : 10'h000,
                     (i < 8) ? 4'(7 - i) : 4'd0);
            check("ret_underflow", 32'(stack_underflow), (i == 8) ? 32'd1 : 32'd0);
        end
        stream(10'h000, 2);

        redirect(10'h005, 10'h3FF, 1'b0, 1'b0, 10'h3FF, 4'd0);
        stream(10'h3FF, 3);

        do_reset();
        stream(10'h000, 4);

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
